// File: rtl/dual_decode_stage.sv
// rtl/dual_decode_stage.sv - two-wide MIPS32 decode stage with output pipeline register
//
// Ports:
//   clk, rst (sync, active-low)      clock and reset
//   pause, flush                     downstream stall / kill
//   pause_req                        to fetch: hold inputs and retry
//   valid{0,1}_i, inst{0,1}_i, pc{0,1}_i   fetched slots (slot 0 older)
//   valid{0,1}_o, uop{0,1}_o, dst{0,1}_o, dstwe{0,1}_o, src0_{0,1}_o,
//   src1_{0,1}_o, op0re{0,1}_o, op1re{0,1}_o, imm{0,1}_o, pco{0,1}_o
//                                    registered uOP bundles for rename
module dual_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    input  logic        flush,
    output logic        pause_req,
    input  logic        valid0_i,
    input  logic [31:0] inst0_i,
    input  logic [31:0] pc0_i,
    input  logic        valid1_i,
    input  logic [31:0] inst1_i,
    input  logic [31:0] pc1_i,
    output logic        valid0_o,
    output logic [4:0]  uop0_o,
    output logic [4:0]  dst0_o,
    output logic        dstwe0_o,
    output logic [4:0]  src0_0_o,
    output logic [4:0]  src1_0_o,
    output logic        op0re0_o,
    output logic        op1re0_o,
    output logic [31:0] imm0_o,
    output logic [31:0] pco0_o,
    output logic        valid1_o,
    output logic [4:0]  uop1_o,
    output logic [4:0]  dst1_o,
    output logic        dstwe1_o,
    output logic [4:0]  src0_1_o,
    output logic [4:0]  src1_1_o,
    output logic        op0re1_o,
    output logic        op1re1_o,
    output logic [31:0] imm1_o,
    output logic [31:0] pco1_o
);

    localparam logic [4:0] UOP_NOP  = 5'd0,  UOP_ADDU  = 5'd1,  UOP_SUBU = 5'd2,
                           UOP_AND  = 5'd3,  UOP_OR    = 5'd4,  UOP_XOR  = 5'd5,
                           UOP_NOR  = 5'd6,  UOP_SLT   = 5'd7,  UOP_SLTU = 5'd8,
                           UOP_SLL  = 5'd9,  UOP_SRL   = 5'd10, UOP_SRA  = 5'd11,
                           UOP_ADDIU= 5'd12, UOP_ANDI  = 5'd13, UOP_ORI  = 5'd14,
                           UOP_XORI = 5'd15, UOP_LUI   = 5'd16, UOP_SLTI = 5'd17,
                           UOP_SLTIU= 5'd18, UOP_LW    = 5'd19, UOP_SW   = 5'd20,
                           UOP_BEQ  = 5'd21, UOP_BNE   = 5'd22, UOP_MULT = 5'd23,
                           UOP_DIV  = 5'd24, UOP_MFHI  = 5'd25, UOP_MFLO = 5'd26,
                           UOP_RESV = 5'd31;

    typedef struct packed {
        logic [4:0]  uop;
        logic [4:0]  dst;
        logic        dstwe;
        logic [4:0]  src0;
        logic [4:0]  src1;
        logic        op0re;
        logic        op1re;
        logic [31:0] imm;
    } uop_t;

    function automatic uop_t decode(input logic [31:0] inst);
        uop_t        d;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] sext;
        logic [31:0] zext;
        op    = inst[31:26];
        funct = inst[5:0];
        rs    = inst[25:21];
        rt    = inst[20:16];
        rd    = inst[15:11];
        sext  = {{16{inst[15]}}, inst[15:0]};
        zext  = {16'h0, inst[15:0]};
        d     = '0;
        if (inst == 32'h0) begin
            d.uop = UOP_NOP;
        end else begin
            case (op)
                6'h00: case (funct)
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        d.dst = rd; d.dstwe = 1'b1; d.src0 = rs; d.src1 = rt;
                        d.op0re = 1'b1; d.op1re = 1'b1;
                        case (funct)
                            6'h21:   d.uop = UOP_ADDU;
                            6'h23:   d.uop = UOP_SUBU;
                            6'h24:   d.uop = UOP_AND;
                            6'h25:   d.uop = UOP_OR;
                            6'h26:   d.uop = UOP_XOR;
                            6'h27:   d.uop = UOP_NOR;
                            6'h2A:   d.uop = UOP_SLT;
                            default: d.uop = UOP_SLTU;
                        endcase
                    end
                    6'h00, 6'h02, 6'h03: begin
                        // Shift amount travels in the immediate; rt is the shifted value.
                        d.uop = (funct == 6'h00) ? UOP_SLL : (funct == 6'h02) ? UOP_SRL : UOP_SRA;
                        d.dst = rd; d.dstwe = 1'b1; d.src0 = rt; d.op0re = 1'b1;
                        d.imm = {27'h0, inst[10:6]};
                    end
                    6'h18, 6'h1A: begin
                        d.uop = (funct == 6'h18) ? UOP_MULT : UOP_DIV;
                        d.src0 = rs; d.src1 = rt; d.op0re = 1'b1; d.op1re = 1'b1;
                    end
                    6'h10, 6'h12: begin
                        d.uop = (funct == 6'h10) ? UOP_MFHI : UOP_MFLO;
                        d.dst = rd; d.dstwe = 1'b1;
                    end
                    default: d.uop = UOP_RESV;
                endcase
                6'h09, 6'h0A, 6'h0B, 6'h23: begin
                    d.uop = (op == 6'h09) ? UOP_ADDIU : (op == 6'h0A) ? UOP_SLTI :
                            (op == 6'h0B) ? UOP_SLTIU : UOP_LW;
                    d.dst = rt; d.dstwe = 1'b1; d.src0 = rs; d.op0re = 1'b1; d.imm = sext;
                end
                6'h0C, 6'h0D, 6'h0E: begin
                    d.uop = (op == 6'h0C) ? UOP_ANDI : (op == 6'h0D) ? UOP_ORI : UOP_XORI;
                    d.dst = rt; d.dstwe = 1'b1; d.src0 = rs; d.op0re = 1'b1; d.imm = zext;
                end
                6'h0F: begin
                    d.uop = UOP_LUI; d.dst = rt; d.dstwe = 1'b1; d.imm = {inst[15:0], 16'h0};
                end
                6'h2B: begin
                    d.uop = UOP_SW; d.src0 = rs; d.src1 = rt;
                    d.op0re = 1'b1; d.op1re = 1'b1; d.imm = sext;
                end
                6'h04, 6'h05: begin
                    d.uop = (op == 6'h04) ? UOP_BEQ : UOP_BNE;
                    d.src0 = rs; d.src1 = rt; d.op0re = 1'b1; d.op1re = 1'b1;
                    d.imm = {sext[29:0], 2'b00};
                end
                default: d.uop = UOP_RESV;
            endcase
        end
        // Writes to $0 are architecturally discarded; never allocate a rename for them.
        if (d.dst == 5'd0) d.dstwe = 1'b0;
        return d;
    endfunction

    uop_t        r0, r1;
    logic        v0, v1;
    logic [31:0] p0, p1;

    // Only stall fetch when there is something held; an empty register keeps loading.
    assign pause_req = pause & (v0 | v1);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            v0 <= 1'b0; r0 <= '0; p0 <= '0;
            v1 <= 1'b0; r1 <= '0; p1 <= '0;
        end else if (!pause_req) begin
            v0 <= valid0_i;
            r0 <= valid0_i ? decode(inst0_i) : '0;
            p0 <= valid0_i ? pc0_i : '0;
            v1 <= valid1_i;
            r1 <= valid1_i ? decode(inst1_i) : '0;
            p1 <= valid1_i ? pc1_i : '0;
        end
    end

    assign valid0_o = v0;       assign valid1_o = v1;
    assign uop0_o   = r0.uop;   assign uop1_o   = r1.uop;
    assign dst0_o   = r0.dst;   assign dst1_o   = r1.dst;
    assign dstwe0_o = r0.dstwe; assign dstwe1_o = r1.dstwe;
    assign src0_0_o = r0.src0;  assign src0_1_o = r1.src0;
    assign src1_0_o = r0.src1;  assign src1_1_o = r1.src1;
    assign op0re0_o = r0.op0re; assign op0re1_o = r1.op0re;
    assign op1re0_o = r0.op1re; assign op1re1_o = r1.op1re;
    assign imm0_o   = r0.imm;   assign imm1_o   = r1.imm;
    assign pco0_o   = p0;       assign pco1_o   = p1;

endmodule

// File: tb/tb_dual_decode_stage.sv
// tb/tb_dual_decode_stage.sv - scoreboard bench for dual_decode_stage
module tb_dual_decode_stage;

    logic        clk = 1'b0;
    logic        rst, pause, flush, pause_req;
    logic        valid0_i, valid1_i;
    logic [31:0] inst0_i, pc0_i, inst1_i, pc1_i;
    logic        valid0_o, dstwe0_o, op0re0_o, op1re0_o;
    logic [4:0]  uop0_o, dst0_o, src0_0_o, src1_0_o;
    logic [31:0] imm0_o, pco0_o;
    logic        valid1_o, dstwe1_o, op0re1_o, op1re1_o;
    logic [4:0]  uop1_o, dst1_o, src0_1_o, src1_1_o;
    logic [31:0] imm1_o, pco1_o;

    always #5 clk = ~clk;

    dual_decode_stage dut (
        .clk(clk), .rst(rst), .pause(pause), .flush(flush), .pause_req(pause_req),
        .valid0_i(valid0_i), .inst0_i(inst0_i), .pc0_i(pc0_i),
        .valid1_i(valid1_i), .inst1_i(inst1_i), .pc1_i(pc1_i),
        .valid0_o(valid0_o), .uop0_o(uop0_o), .dst0_o(dst0_o), .dstwe0_o(dstwe0_o),
        .src0_0_o(src0_0_o), .src1_0_o(src1_0_o), .op0re0_o(op0re0_o), .op1re0_o(op1re0_o),
        .imm0_o(imm0_o), .pco0_o(pco0_o),
        .valid1_o(valid1_o), .uop1_o(uop1_o), .dst1_o(dst1_o), .dstwe1_o(dstwe1_o),
        .src0_1_o(src0_1_o), .src1_1_o(src1_1_o), .op0re1_o(op0re1_o), .op1re1_o(op1re1_o),
        .imm1_o(imm1_o), .pco1_o(pco1_o)
    );

    typedef struct {
        logic        v;
        logic [4:0]  uop, dst;
        logic        we;
        logic [4:0]  s0, s1;
        logic        re0, re1;
        logic [31:0] imm, pc;
    } slot_t;

    typedef struct {
        slot_t a;
        slot_t b;
    } pair_t;

    localparam int N = 16;
    logic [31:0] t_inst[N];
    logic [31:0] t_imm[N];
    logic [4:0]  t_uop[N], t_dst[N], t_s0[N], t_s1[N];
    logic        t_we[N], t_re0[N], t_re1[N];

    pair_t q[$];
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic entry(input int i, input logic [31:0] inst, input logic [4:0] uop,
                         input logic [4:0] dst, input logic we, input logic [4:0] s0,
                         input logic [4:0] s1, input logic re0, input logic re1,
                         input logic [31:0] imm);
        t_inst[i] = inst; t_uop[i] = uop; t_dst[i] = dst; t_we[i] = we;
        t_s0[i] = s0; t_s1[i] = s1; t_re0[i] = re0; t_re1[i] = re1; t_imm[i] = imm;
    endtask

    function automatic slot_t mk(input int i, input logic v, input logic [31:0] pc);
        slot_t s;
        s = '{v: 1'b0, uop: 5'd0, dst: 5'd0, we: 1'b0, s0: 5'd0, s1: 5'd0,
              re0: 1'b0, re1: 1'b0, imm: 32'd0, pc: 32'd0};
        if (v) begin
            s.v = 1'b1; s.uop = t_uop[i]; s.dst = t_dst[i]; s.we = t_we[i];
            s.s0 = t_s0[i]; s.s1 = t_s1[i]; s.re0 = t_re0[i]; s.re1 = t_re1[i];
            s.imm = t_imm[i]; s.pc = pc;
        end
        return s;
    endfunction

    // Drives both slots and returns the bundle the register should hold after loading them.
    task automatic drive(input int i0, input logic v0, input int i1, input logic v1,
                         output pair_t e);
        logic [31:0] pa, pb;
        pa = $urandom & 32'hFFFF_FFFC;
        pb = pa + 32'd4;
        valid0_i = v0; inst0_i = t_inst[i0]; pc0_i = pa;
        valid1_i = v1; inst1_i = t_inst[i1]; pc1_i = pb;
        e.a = mk(i0, v0, pa);
        e.b = mk(i1, v1, pb);
    endtask

    task automatic compare(input string tag, input pair_t e);
        check({tag, " v0"},    {31'd0, valid0_o}, {31'd0, e.a.v});
        check({tag, " uop0"},  {27'd0, uop0_o},   {27'd0, e.a.uop});
        check({tag, " dst0"},  {27'd0, dst0_o},   {27'd0, e.a.dst});
        check({tag, " we0"},   {31'd0, dstwe0_o}, {31'd0, e.a.we});
        check({tag, " s0_0"},  {27'd0, src0_0_o}, {27'd0, e.a.s0});
        check({tag, " s1_0"},  {27'd0, src1_0_o}, {27'd0, e.a.s1});
        check({tag, " re0_0"}, {31'd0, op0re0_o}, {31'd0, e.a.re0});
        check({tag, " re1_0"}, {31'd0, op1re0_o}, {31'd0, e.a.re1});
        check({tag, " imm0"},  imm0_o, e.a.imm);
        check({tag, " pc0"},   pco0_o, e.a.pc);
        check({tag, " v1"},    {31'd0, valid1_o}, {31'd0, e.b.v});
        check({tag, " uop1"},  {27'd0, uop1_o},   {27'd0, e.b.uop});
        check({tag, " dst1"},  {27'd0, dst1_o},   {27'd0, e.b.dst});
        check({tag, " we1"},   {31'd0, dstwe1_o}, {31'd0, e.b.we});
        check({tag, " s0_1"},  {27'd0, src0_1_o}, {27'd0, e.b.s0});
        check({tag, " s1_1"},  {27'd0, src1_1_o}, {27'd0, e.b.s1});
        check({tag, " re0_1"}, {31'd0, op0re1_o}, {31'd0, e.b.re0});
        check({tag, " re1_1"}, {31'd0, op1re1_o}, {31'd0, e.b.re1});
        check({tag, " imm1"},  imm1_o, e.b.imm);
        check({tag, " pc1"},   pco1_o, e.b.pc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_compare(input string tag);
        pair_t e;
        if (q.size() == 0) begin
            check({tag, " queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            compare(tag, e);
        end
    endtask

    initial begin
        pair_t e, held, zero;

        entry(0,  32'h00851021, 5'd1,  5'd2, 1, 5'd4, 5'd5, 1, 1, 32'h0);
        entry(1,  32'h2403FFFF, 5'd12, 5'd3, 1, 5'd0, 5'd0, 1, 0, 32'hFFFFFFFF);
        entry(2,  32'h3403FFFF, 5'd14, 5'd3, 1, 5'd0, 5'd0, 1, 0, 32'h0000FFFF);
        entry(3,  32'h3C011234, 5'd16, 5'd1, 1, 5'd0, 5'd0, 0, 0, 32'h12340000);
        entry(4,  32'h00031100, 5'd9,  5'd2, 1, 5'd3, 5'd0, 1, 0, 32'h4);
        entry(5,  32'hAC850008, 5'd20, 5'd0, 0, 5'd4, 5'd5, 1, 1, 32'h8);
        entry(6,  32'hFC000000, 5'd31, 5'd0, 0, 5'd0, 5'd0, 0, 0, 32'h0);
        entry(7,  32'h00000000, 5'd0,  5'd0, 0, 5'd0, 5'd0, 0, 0, 32'h0);
        entry(8,  32'h1085FFFF, 5'd21, 5'd0, 0, 5'd4, 5'd5, 1, 1, 32'hFFFFFFFC);
        entry(9,  32'h00850021, 5'd1,  5'd0, 0, 5'd4, 5'd5, 1, 1, 32'h0);
        entry(10, 32'h8C85FFF0, 5'd19, 5'd5, 1, 5'd4, 5'd0, 1, 0, 32'hFFFFFFF0);
        entry(11, 32'h00850018, 5'd23, 5'd0, 0, 5'd4, 5'd5, 1, 1, 32'h0);
        entry(12, 32'h00001012, 5'd26, 5'd2, 1, 5'd0, 5'd0, 0, 0, 32'h0);
        entry(13, 32'h00031103, 5'd11, 5'd2, 1, 5'd3, 5'd0, 1, 0, 32'h4);
        entry(14, 32'h0000003F, 5'd31, 5'd0, 0, 5'd0, 5'd0, 0, 0, 32'h0);
        entry(15, 32'h3085FFFF, 5'd13, 5'd5, 1, 5'd4, 5'd0, 1, 0, 32'h0000FFFF);

        zero.a = mk(0, 1'b0, 32'd0);
        zero.b = mk(0, 1'b0, 32'd0);

        // Reset with valid-looking inputs present: register must stay clear.
        rst = 1'b0; pause = 1'b0; flush = 1'b0;
        drive(0, 1'b1, 1, 1'b1, e);
        tick; tick;
        compare("reset", zero);
        check("reset pause_req", {31'd0, pause_req}, 32'd0);
        rst = 1'b1;

        // Every table entry through both slots, with varying slot valids.
        for (int k = 0; k < N; k++) begin
            drive(k, (k % 5) != 3, (k + 5) % N, (k % 4) != 2, e);
            q.push_back(e);
            tick;
            pop_compare($sformatf("dec%0d", k));
        end

        // Hold while paused, then load the held inputs on release.
        drive(0, 1'b1, 3, 1'b1, e);
        q.push_back(e);
        tick;
        held = e;
        pop_compare("pre_pause");
        pause = 1'b1;
        #1;
        check("pause_req set", {31'd0, pause_req}, 32'd1);
        drive(4, 1'b1, 5, 1'b1, e);
        tick;
        compare("paused", held);
        drive(4, 1'b1, 5, 1'b1, e);
        tick;
        compare("paused2", held);
        check("pause_req held", {31'd0, pause_req}, 32'd1);
        pause = 1'b0;
        q.push_back(e);
        tick;
        pop_compare("release");

        // Flush beats pause.
        pause = 1'b1; flush = 1'b1;
        drive(6, 1'b1, 8, 1'b1, e);
        tick;
        compare("flush", zero);
        check("flush pause_req", {31'd0, pause_req}, 32'd0);
        flush = 1'b0;

        // Pause with an empty register still loads.
        drive(10, 1'b1, 12, 1'b0, e);
        q.push_back(e);
        tick;
        pop_compare("pause_empty");
        check("pause_req after load", {31'd0, pause_req}, 32'd1);
        pause = 1'b0;

        // Reset while loaded.
        rst = 1'b0;
        tick;
        compare("reset2", zero);
        rst = 1'b1;

        check("queue drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
